// File: rtl/tele_rx.sv
//==============================================================================
// Module   : tele_rx
// Function : Serial telemetry frame receiver (preamble lock, parity, counters)
// Revision : 1.0
//==============================================================================
`default_nettype none

module tele_rx #(
  parameter int GAP_MIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic        o_rx_flag,
  output logic [6:0]  o_rx_addr,
  output logic [3:0]  o_rx_data,
  output logic        o_rx_err,
  output logic        o_busy,
  output logic [15:0] o_frm_cnt,
  output logic [7:0]  o_err_cnt
);

  localparam logic [2:0] HUNT  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] PRE   = 3'd2;
  localparam logic [2:0] RECV  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] GAP_Q = GAP_MIN[3:0];

  logic        rx_q;
  logic [2:0]  state_q, state_d;
  logic [3:0]  zrun_q, zrun_d;
  logic [1:0]  pre_idx_q, pre_idx_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [11:0] shreg_q, shreg_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic [15:0] frm_q, frm_d;
  logic [7:0]  errc_q, errc_d;
  logic        busy;

  // State register and all other flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q      <= 1'b0;
      state_q   <= HUNT;
      zrun_q    <= 4'd0;
      pre_idx_q <= 2'd0;
      bcnt_q    <= 4'd0;
      shreg_q   <= 12'd0;
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= 7'd0;
      data_q    <= 4'd0;
      frm_q     <= 16'd0;
      errc_q    <= 8'd0;
    end else begin
      rx_q      <= i_rx;
      state_q   <= state_d;
      zrun_q    <= zrun_d;
      pre_idx_q <= pre_idx_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      frm_q     <= frm_d;
      errc_q    <= errc_d;
    end
  end

  // Next-state and framing datapath
  always_comb begin
    state_d   = state_q;
    zrun_d    = zrun_q;
    pre_idx_d = pre_idx_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      HUNT: begin
        if (rx_q) begin
          zrun_d = 4'd0;
        end else begin
          if (zrun_q < GAP_Q) zrun_d = zrun_q + 4'd1;
          if (zrun_d >= GAP_Q) state_d = ARMED;
        end
      end
      ARMED: begin
        if (rx_q) begin
          state_d   = PRE;
          pre_idx_d = 2'd1;
          zrun_d    = 4'd0;
        end
      end
      PRE: begin
        // Remaining preamble bits are 0,1,0 for indices 1,2,3
        if (rx_q != (pre_idx_q == 2'd2)) begin
          state_d = HUNT;
          zrun_d  = {3'd0, ~rx_q};
        end else if (pre_idx_q == 2'd3) begin
          state_d = RECV;
          bcnt_d  = 4'd0;
        end else begin
          pre_idx_d = pre_idx_q + 2'd1;
        end
      end
      RECV: begin
        shreg_d = {shreg_q[10:0], rx_q};
        if (bcnt_q == 4'd11) state_d = DONE;
        else                 bcnt_d  = bcnt_q + 4'd1;
      end
      DONE: begin
        state_d = HUNT;
        zrun_d  = 4'd0;
      end
      default: begin
        state_d = HUNT;
        zrun_d  = 4'd0;
      end
    endcase
  end

  // Outputs: parity verdict is pipelined one stage before the strobes
  always_comb begin
    busy   = (state_q == PRE) || (state_q == RECV) || (state_q == DONE);
    ok_d   = (state_q == DONE) && !(^shreg_q);
    bad_d  = (state_q == DONE) && (^shreg_q);
    flag_d = ok_q;
    err_d  = bad_q;
    addr_d = ok_q ? shreg_q[11:5] : addr_q;
    data_d = ok_q ? shreg_q[4:1]  : data_q;
    frm_d  = frm_q + {15'd0, ok_q};
    errc_d = (bad_q && (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;
  end

  assign o_rx_flag = flag_q;
  assign o_rx_err  = err_q;
  assign o_rx_addr = addr_q;
  assign o_rx_data = data_q;
  assign o_frm_cnt = frm_q;
  assign o_err_cnt = errc_q;
  assign o_busy    = busy;

endmodule

`default_nettype wire

// File: tb/tb_tele_rx.sv
//==============================================================================
// Module   : tb_tele_rx
// Function : Self-checking bench for tele_rx (stream model + literal checks)
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tele_rx;

  localparam int GAP_MIN = 8;
  localparam logic [3:0] PREAMBLE = 4'b1010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rx = 1'b0;
  logic        o_rx_flag, o_rx_err, o_busy;
  logic [6:0]  o_rx_addr;
  logic [3:0]  o_rx_data;
  logic [15:0] o_frm_cnt;
  logic [7:0]  o_err_cnt;

  tele_rx #(.GAP_MIN(GAP_MIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (i_rx),
    .o_rx_flag (o_rx_flag),
    .o_rx_addr (o_rx_addr),
    .o_rx_data (o_rx_data),
    .o_rx_err  (o_rx_err),
    .o_busy    (o_busy),
    .o_frm_cnt (o_frm_cnt),
    .o_err_cnt (o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Stream model: bit n is sampled at edge n; results land at edge n+3
  int          mz, mpos;
  logic [15:0] mfr;
  int          ev_kind[int];
  logic [10:0] ev_pay[int];
  bit          busy_at[int];
  logic [6:0]  m_addr;
  logic [3:0]  m_data;
  logic [15:0] m_frm;
  logic [7:0]  m_errc;
  bit          e_flag, e_err, e_busy;

  task automatic model_bit(input logic b, input int n);
    if (mpos < 0) begin
      if (!b)                mz++;
      else if (mz >= GAP_MIN) begin mpos = 1; mfr = 16'h0001; end
      else                   mz = 0;
    end else if (mpos <= 3) begin
      if (b != PREAMBLE[3-mpos]) begin
        mpos = -1;
        mz   = b ? 0 : 1;
      end else begin
        mfr = {mfr[14:0], b};
        mpos++;
      end
    end else if (mpos <= 15) begin
      mfr = {mfr[14:0], b};
      if (mpos == 15) begin
        ev_kind[n+3] = (^mfr == 1'b0) ? 1 : 2;
        ev_pay[n+3]  = mfr[11:1];
      end
      mpos++;
    end else begin
      mpos = -1;
      mz   = 0;
    end
    busy_at[n+1] = (mpos >= 1);
  endtask

  task automatic model_reset();
    mz = 0; mpos = -1; mfr = 16'd0;
    m_addr = 7'd0; m_data = 4'd0; m_frm = 16'd0; m_errc = 8'd0;
    ev_kind.delete(); ev_pay.delete(); busy_at.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_flag = 1'b0;
      e_err  = 1'b0;
      e_busy = busy_at.exists(cyc) ? busy_at[cyc] : 1'b0;
      if (ev_kind.exists(cyc)) begin
        if (ev_kind[cyc] == 1) begin
          e_flag = 1'b1;
          m_addr = ev_pay[cyc][10:4];
          m_data = ev_pay[cyc][3:0];
          m_frm  = m_frm + 16'd1;
        end else begin
          e_err = 1'b1;
          if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        end
        ev_kind.delete(cyc);
      end
      n_chk++;
      if ({o_rx_flag, o_rx_err, o_busy, o_rx_addr, o_rx_data, o_frm_cnt, o_err_cnt} !==
          {e_flag, e_err, e_busy, m_addr, m_data, m_frm, m_errc}) begin
        n_fail++;
        $display("FAIL model cyc=%0d got flag=%b err=%b busy=%b addr=%h data=%h frm=%0d errc=%0d exp flag=%b err=%b busy=%b addr=%h data=%h frm=%0d errc=%0d",
                 cyc, o_rx_flag, o_rx_err, o_busy, o_rx_addr, o_rx_data, o_frm_cnt, o_err_cnt,
                 e_flag, e_err, e_busy, m_addr, m_data, m_frm, m_errc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {o_rx_flag, o_rx_err, o_busy, o_rx_addr, o_rx_data, o_frm_cnt, o_err_cnt}, 32'd0);
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    @(posedge clk);
    cyc++;
    model_bit(b, cyc);
    #1;
  endtask

  task automatic send_frame(input logic [6:0] a, input logic [3:0] d, input logic inv, input int gap);
    logic [15:0] f;
    f = {PREAMBLE, a, d, (^{a, d}) ^ inv};
    for (int i = 15; i >= 0; i--) send_bit(f[i]);
    for (int i = 0; i < gap; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst    = 1'b1;
    i_rx   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    model_reset();
    cyc = 0;
    model_bit(1'b0, 0);   // reset value of the input register is consumed first
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    // Test 1: first frame after start-up idle, with latency pinned by hand
    do_reset();
    for (int i = 0; i < 2000; i++) send_bit(1'b0);
    send_frame(7'h05, 4'h5, 1'b0, 0);
    send_bit(1'b0); send_bit(1'b0);
    chk("lat_p2_flag", {31'd0, o_rx_flag}, 32'd0);
    send_bit(1'b0);
    chk("lat_p3_flag", {31'd0, o_rx_flag}, 32'd1);
    chk("t1_addr", {25'd0, o_rx_addr}, 32'h05);
    chk("t1_data", {28'd0, o_rx_data}, 32'h5);
    chk("t1_frm", {16'd0, o_frm_cnt}, 32'd1);
    send_bit(1'b0);
    chk("lat_p4_flag", {31'd0, o_rx_flag}, 32'd0);
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    chk("t1_errc", {24'd0, o_err_cnt}, 32'd0);

    // Test 2: 128 back-to-back frames
    do_reset();
    for (int i = 0; i < 2000; i++) send_bit(1'b0);
    for (int a = 0; a < 128; a++) send_frame(7'(a), 4'(a), 1'b0, 20);
    chk("t2_frm", {16'd0, o_frm_cnt}, 32'd128);
    chk("t2_errc", {24'd0, o_err_cnt}, 32'd0);
    chk("t2_addr", {25'd0, o_rx_addr}, 32'h7F);

    // Test 3: good frame, then bad parity must not disturb addr/data
    send_frame(7'h11, 4'h3, 1'b0, 20);
    send_frame(7'h7F, 4'hF, 1'b1, 20);
    chk("t3_errc", {24'd0, o_err_cnt}, 32'd1);
    chk("t3_addr", {25'd0, o_rx_addr}, 32'h11);
    chk("t3_data", {28'd0, o_rx_data}, 32'h3);
    chk("t3_frm", {16'd0, o_frm_cnt}, 32'd129);

    // Test 4: short gap drops the frame, proper gap decodes the next
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_frame(7'h33, 4'h3, 1'b0, 8);
    chk("t4_drop_frm", {16'd0, o_frm_cnt}, 32'd129);
    send_frame(7'h2A, 4'hA, 1'b0, 20);
    chk("t4_frm", {16'd0, o_frm_cnt}, 32'd130);
    chk("t4_addr", {25'd0, o_rx_addr}, 32'h2A);
    chk("t4_data", {28'd0, o_rx_data}, 32'hA);

    // Test 5: preamble-like payload, then another frame
    send_frame(7'h55, 4'hA, 1'b0, 20);
    chk("t5_addr1", {25'd0, o_rx_addr}, 32'h55);
    send_frame(7'h12, 4'h4, 1'b0, 20);
    chk("t5_frm", {16'd0, o_frm_cnt}, 32'd132);
    chk("t5_addr2", {25'd0, o_rx_addr}, 32'h12);

    // Test 6: asynchronous reset in the middle of a payload
    for (int i = 0; i < 4; i++) send_bit(PREAMBLE[3-i]);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("t6_busy", {31'd0, o_busy}, 32'd1);
    #2;
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk_zero("t6_async_clear");
    do_reset();
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    send_frame(7'h3C, 4'h6, 1'b0, 20);
    chk("t6_frm", {16'd0, o_frm_cnt}, 32'd1);
    chk("t6_addr", {25'd0, o_rx_addr}, 32'h3C);

    // Test 7: error counter saturation
    for (int i = 0; i < 256; i++) send_frame(7'h7F, 4'hF, 1'b1, 20);
    chk("t7_errc_sat", {24'd0, o_err_cnt}, 32'd255);
    chk("t7_frm", {16'd0, o_frm_cnt}, 32'd1);

    // Test 8: line stuck high
    for (int i = 0; i < 60; i++) send_bit(1'b1);
    chk("t8_busy", {31'd0, o_busy}, 32'd0);
    chk("t8_frm", {16'd0, o_frm_cnt}, 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
